// File: rtl/key_fifo_if.sv
// Keyboard buffer bus: scanner push side, CPU pop side and status outputs.
// The FIFO itself connects through the slave modport.
interface key_fifo_if #(
  parameter int DEPTH = 8
);
  logic [6:0]                   key_in;
  logic                         key_valid;
  logic                         key_held;
  logic                         keystrobe;
  logic                         clr_overflow;
  logic [7:0]                   keycode;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow;

  modport master (
    output key_in, key_valid, key_held, keystrobe, clr_overflow,
    input  keycode, count, overflow
  );

  modport slave (
    input  key_in, key_valid, key_held, keystrobe, clr_overflow,
    output keycode, count, overflow
  );
endinterface

// File: rtl/key_fifo.sv
// Keyboard input FIFO presenting {ready, ascii} to the CPU, popped on keystrobe rising edges.
// Define KEY_FIFO_REPEAT_EN to add typematic auto-repeat of the last key while it is held.
module key_fifo #(
  parameter int          DEPTH        = 8,
  parameter logic [15:0] REPEAT_DELAY = 16'd500,
  parameter logic [15:0] REPEAT_RATE  = 16'd100
) (
  input logic       clk,
  input logic       reset,
  key_fifo_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [6:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    keycode_q, keycode_d;
  logic          overflow_q;
  logic          strobe_q;
  logic          pop_req, pop, space, ext_push, int_push, push, drop;
  logic [6:0]    push_data;

  assign pop_req  = bus.keystrobe & ~strobe_q;
  assign pop      = pop_req & (count_q != '0);
  assign space    = (count_q != FULL_COUNT) | pop;
  assign ext_push = bus.key_valid & space;
  assign drop     = bus.key_valid & ~space;
  assign push     = ext_push | int_push;

`ifdef KEY_FIFO_REPEAT_EN
  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} repeat_state_t;

  repeat_state_t state_q, state_d;
  logic [15:0]   rcnt_q, rcnt_d;
  logic [6:0]    last_q, last_d;
  logic          rep_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= R_IDLE;
      rcnt_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      last_q  <= last_d;
    end
  end

  // Any key event, accepted or dropped, restarts the delay; releasing the key stops repeating.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    last_d   = last_q;
    rep_fire = 1'b0;
    if (bus.key_valid) begin
      last_d  = bus.key_in;
      rcnt_d  = '0;
      state_d = R_DELAY;
    end else if (!bus.key_held) begin
      rcnt_d  = '0;
      state_d = R_IDLE;
    end else begin
      case (state_q)
        R_DELAY: begin
          if (rcnt_q == REPEAT_DELAY - 16'd1) begin
            rep_fire = 1'b1;
            rcnt_d   = '0;
            state_d  = R_REPEAT;
          end else begin
            rcnt_d = rcnt_q + 16'd1;
          end
        end
        R_REPEAT: begin
          if (rcnt_q == REPEAT_RATE - 16'd1) begin
            rep_fire = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + 16'd1;
          end
        end
        default: begin
          state_d = R_IDLE;
        end
      endcase
    end
  end

  assign int_push  = rep_fire & space;
  assign push_data = bus.key_valid ? bus.key_in : last_q;
`else
  logic unused_repeat;
  assign unused_repeat = bus.key_held ^ (^REPEAT_DELAY) ^ (^REPEAT_RATE);
  assign int_push      = 1'b0;
  assign push_data     = bus.key_in;
`endif

  // The head after this edge is either an older stored entry or the word being written now.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = pop ? rd_ptr + PW'(1) : rd_ptr;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (count_d == '0) begin
      keycode_d = 8'h00;
    end else if (push && (rd_ptr_d == wr_ptr)) begin
      keycode_d = {1'b1, push_data};
    end else begin
      keycode_d = {1'b1, mem[rd_ptr_d]};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      keycode_q  <= 8'h00;
      overflow_q <= 1'b0;
      strobe_q   <= 1'b1;
    end else begin
      strobe_q  <= bus.keystrobe;
      rd_ptr    <= rd_ptr_d;
      count_q   <= count_d;
      keycode_q <= keycode_d;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.keycode  = keycode_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule
